// File: rtl/instr_fetcher_pkg.sv
// Shared opcodes, fetch FSM state encoding and RV32I immediate decoders
// used by the fetch stage and its next-PC calculator.
package instr_fetcher_pkg;

  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    IF_REQ   = 2'd0,
    IF_OUT   = 2'd1,
    IF_DRAIN = 2'd2
  } if_state_e;

  function automatic logic [31:0] imm_j(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/instr_fetcher_if.sv
// Bundle of the fetch stage's icache, predictor, decoder and ROB-redirect signals.
// The master modport is the fetch stage; the slave modport is its environment.
interface instr_fetcher_if;

  logic        if2ic_valid;
  logic [31:0] if2ic_addr;
  logic        ic2if_valid;
  logic [31:0] ic2if_instr;

  logic [31:0] if2pred_pc;
  logic        pred2if_result;

  logic        if2dec_valid;
  logic [31:0] if2dec_instr;
  logic [31:0] if2dec_pc;
  logic        if2dec_pred_jump;
  logic        dec2if_ready;

  logic        rob_flush;
  logic [31:0] rob_target_pc;

  modport master (
    output if2ic_valid, if2ic_addr, if2pred_pc,
    output if2dec_valid, if2dec_instr, if2dec_pc, if2dec_pred_jump,
    input  ic2if_valid, ic2if_instr, pred2if_result, dec2if_ready,
    input  rob_flush, rob_target_pc
  );

  modport slave (
    input  if2ic_valid, if2ic_addr, if2pred_pc,
    input  if2dec_valid, if2dec_instr, if2dec_pc, if2dec_pred_jump,
    output ic2if_valid, ic2if_instr, pred2if_result, dec2if_ready,
    output rob_flush, rob_target_pc
  );

endinterface

// File: rtl/instr_fetcher_next_pc.sv
// Combinational next-PC selection from the captured instruction and the
// predictor's taken bit; addition wraps modulo 2^32.
module next_pc_calc
  import instr_fetcher_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        pred_taken,
  output logic [31:0] npc,
  output logic        pred_jump
);

  // JALR targets depend on a register value, so fall through and let the ROB redirect.
  always_comb begin
    npc       = pc + 32'd4;
    pred_jump = 1'b0;
    case (instr[6:0])
      OPCODE_JAL: begin
        npc       = pc + imm_j(instr);
        pred_jump = 1'b1;
      end
      OPCODE_BRANCH: begin
        if (pred_taken) begin
          npc       = pc + imm_b(instr);
          pred_jump = 1'b1;
        end
      end
      OPCODE_JALR: begin
        npc       = pc + 32'd4;
        pred_jump = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_fetcher.sv
// Fetch stage: one outstanding icache request, a single output slot toward the
// decoder, and ROB redirects that squash any response still in flight.
module instr_fetcher
  import instr_fetcher_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic rdy_in,
  instr_fetcher_if.master bus
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] npc_q, npc_d;
  logic        dec_valid_q, dec_valid_d;
  logic [31:0] dec_instr_q, dec_instr_d;
  logic [31:0] dec_pc_q, dec_pc_d;
  logic        pred_jump_q, pred_jump_d;

  logic [31:0] calc_npc;
  logic        calc_pred_jump;
  logic        redirect, capture, accept;

  next_pc_calc u_next_pc (
    .pc        (pc_q),
    .instr     (bus.ic2if_instr),
    .pred_taken(bus.pred2if_result),
    .npc       (calc_npc),
    .pred_jump (calc_pred_jump)
  );

  // A flush outranks both capture and decoder acceptance in the same cycle.
  assign redirect = rdy_in & bus.rob_flush;
  assign capture  = rdy_in & ~bus.rob_flush & (state_q == IF_REQ) & bus.ic2if_valid;
  assign accept   = rdy_in & ~bus.rob_flush & (state_q == IF_OUT) & dec_valid_q & bus.dec2if_ready;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= IF_REQ;
    else         state_q <= state_d;
  end

  // DRAIN means a squashed response is still owed by the icache.
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      case (state_q)
        IF_REQ, IF_DRAIN: state_d = bus.ic2if_valid ? IF_REQ : IF_DRAIN;
        default:          state_d = IF_REQ;
      endcase
    end else if (rdy_in) begin
      case (state_q)
        IF_REQ:   if (capture)         state_d = IF_OUT;
        IF_OUT:   if (accept)          state_d = IF_REQ;
        IF_DRAIN: if (bus.ic2if_valid) state_d = IF_REQ;
        default:                       state_d = IF_REQ;
      endcase
    end
  end

  always_comb begin
    pc_d        = pc_q;
    npc_d       = npc_q;
    dec_valid_d = dec_valid_q;
    dec_instr_d = dec_instr_q;
    dec_pc_d    = dec_pc_q;
    pred_jump_d = pred_jump_q;
    if (redirect) begin
      pc_d        = bus.rob_target_pc;
      dec_valid_d = 1'b0;
    end else if (capture) begin
      dec_valid_d = 1'b1;
      dec_instr_d = bus.ic2if_instr;
      dec_pc_d    = pc_q;
      pred_jump_d = calc_pred_jump;
      npc_d       = calc_npc;
    end else if (accept) begin
      dec_valid_d = 1'b0;
      pc_d        = npc_q;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pc_q        <= RESET_PC;
      npc_q       <= 32'h0;
      dec_valid_q <= 1'b0;
      dec_instr_q <= 32'h0;
      dec_pc_q    <= 32'h0;
      pred_jump_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      npc_q       <= npc_d;
      dec_valid_q <= dec_valid_d;
      dec_instr_q <= dec_instr_d;
      dec_pc_q    <= dec_pc_d;
      pred_jump_q <= pred_jump_d;
    end
  end

  always_comb begin
    bus.if2ic_valid      = rst_in & (state_q == IF_REQ);
    bus.if2ic_addr       = pc_q;
    bus.if2pred_pc       = pc_q;
    bus.if2dec_valid     = dec_valid_q;
    bus.if2dec_instr     = dec_instr_q;
    bus.if2dec_pc        = dec_pc_q;
    bus.if2dec_pred_jump = pred_jump_q;
  end

endmodule

// File: tb/tb_instr_fetcher.sv
// Scoreboard bench for instr_fetcher: an icache model with fixed latency, directed
// redirects/stalls/freezes, and monitors that pop expected requests and decoder outputs.
module tb_instr_fetcher;

  localparam logic [31:0] NOP_I = 32'h0000_0013;
  localparam logic [31:0] JAL_I = 32'h0100_006F;
  localparam logic [31:0] BR_I  = 32'hFE00_0EE3;
  localparam int          IC_LATENCY = 2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pj;
  } dec_item_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rdy   = 1'b1;

  logic        resp_en     = 1'b1;
  logic        resp_valid  = 1'b0;
  logic [31:0] resp_instr  = 32'h0;
  logic        force_valid = 1'b0;
  logic [31:0] force_instr = 32'h0;

  dec_item_t   exp_dec[$];
  logic [31:0] exp_req[$];
  int          checks  = 0;
  int          fails   = 0;
  int          acc_cnt = 0;

  instr_fetcher_if bus_if();

  instr_fetcher #(.RESET_PC(32'h0000_0000)) dut (
    .clk_in(clk),
    .rst_in(rst_n),
    .rdy_in(rdy),
    .bus   (bus_if)
  );

  assign bus_if.ic2if_valid = resp_valid | force_valid;
  assign bus_if.ic2if_instr = force_valid ? force_instr : resp_instr;

  always #5 clk = ~clk;

  function automatic logic [31:0] memRead(input logic [31:0] addr);
    case (addr)
      32'h8:   return JAL_I;
      32'h10:  return BR_I;
      default: return NOP_I;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic ready, input logic flush,
                               input logic [31:0] target, input logic pred);
    bus_if.dec2if_ready   = ready;
    bus_if.rob_flush      = flush;
    bus_if.rob_target_pc  = target;
    bus_if.pred2if_result = pred;
  endtask

  task automatic pushDec(input logic [31:0] instr, input logic [31:0] pc, input logic pj);
    dec_item_t e;
    e.instr = instr;
    e.pc    = pc;
    e.pj    = pj;
    exp_dec.push_back(e);
  endtask

  task automatic waitAcc(input int n, input int max_cyc);
    int cyc = 0;
    while (acc_cnt < n && cyc < max_cyc) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (acc_cnt < n) begin
      fails++;
      $display("[TB] FAIL wait_accept: got %0d accepts, expected %0d", acc_cnt, n);
    end
  endtask

  task automatic waitDecValid(input int max_cyc);
    int cyc = 0;
    while (bus_if.if2dec_valid !== 1'b1 && cyc < max_cyc) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("wait_dec_valid", 32'(bus_if.if2dec_valid), 32'd1);
  endtask

  // icache model: latches one request and answers with a one-cycle pulse
  initial begin : icache_model
    bit          pending = 1'b0;
    int          cnt     = 0;
    logic [31:0] raddr   = 32'h0;
    forever begin
      @(posedge clk); #2;
      resp_valid = 1'b0;
      if (!rst_n) begin
        pending = 1'b0;
      end else if (pending) begin
        if (cnt == 1) begin
          resp_valid = 1'b1;
          resp_instr = memRead(raddr);
          pending    = 1'b0;
        end else begin
          cnt--;
        end
      end else if (resp_en && bus_if.if2ic_valid) begin
        pending = 1'b1;
        cnt     = IC_LATENCY;
        raddr   = bus_if.if2ic_addr;
      end
    end
  end

  initial begin : req_monitor
    logic        prev_v = 1'b0;
    logic [31:0] prev_a = 32'h0;
    forever begin
      @(negedge clk);
      if (bus_if.if2ic_valid && (!prev_v || bus_if.if2ic_addr != prev_a)) begin
        if (exp_req.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL unexpected_req: got addr 0x%08h, expected no request", bus_if.if2ic_addr);
        end else begin
          checkOutput("req_addr", bus_if.if2ic_addr, exp_req.pop_front());
        end
      end
      prev_v = bus_if.if2ic_valid;
      prev_a = bus_if.if2ic_addr;
    end
  end

  initial begin : dec_monitor
    dec_item_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rdy && bus_if.if2dec_valid && bus_if.dec2if_ready && !bus_if.rob_flush) begin
        acc_cnt++;
        if (exp_dec.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL unexpected_dec: got pc 0x%08h, expected no output", bus_if.if2dec_pc);
        end else begin
          e = exp_dec.pop_front();
          checkOutput("dec_instr", bus_if.if2dec_instr, e.instr);
          checkOutput("dec_pc", bus_if.if2dec_pc, e.pc);
          checkOutput("dec_pred_jump", 32'(bus_if.if2dec_pred_jump), 32'(e.pj));
        end
      end
    end
  end

  initial begin : main
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ic_valid", 32'(bus_if.if2ic_valid), 32'd0);
    checkOutput("rst_dec_valid", 32'(bus_if.if2dec_valid), 32'd0);
    checkOutput("rst_dec_instr", bus_if.if2dec_instr, 32'h0);
    checkOutput("rst_dec_pc", bus_if.if2dec_pc, 32'h0);
    checkOutput("rst_pred_jump", 32'(bus_if.if2dec_pred_jump), 32'd0);

    // straight-line fetch, then a JAL to 0x18
    exp_req.push_back(32'h0);
    exp_req.push_back(32'h4);
    exp_req.push_back(32'h8);
    exp_req.push_back(32'h18);
    pushDec(NOP_I, 32'h0, 1'b0);
    pushDec(NOP_I, 32'h4, 1'b0);
    pushDec(JAL_I, 32'h8, 1'b1);
    rst_n = 1'b1;
    #1;
    checkOutput("first_req_valid", 32'(bus_if.if2ic_valid), 32'd1);
    checkOutput("first_req_addr", bus_if.if2ic_addr, 32'h0);
    @(posedge clk); #1;
    checkOutput("cyc1_dec_valid", 32'(bus_if.if2dec_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("cyc2_dec_valid", 32'(bus_if.if2dec_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("cyc3_dec_valid", 32'(bus_if.if2dec_valid), 32'd1);
    checkOutput("cyc3_dec_pc", bus_if.if2dec_pc, 32'h0);
    checkOutput("cyc3_pred_jump", 32'(bus_if.if2dec_pred_jump), 32'd0);
    waitAcc(3, 50);

    // decoder stall on the instruction at 0x18
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    pushDec(NOP_I, 32'h18, 1'b0);
    exp_req.push_back(32'h1C);
    waitDecValid(20);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("stall_dec_valid", 32'(bus_if.if2dec_valid), 32'd1);
      checkOutput("stall_dec_instr", bus_if.if2dec_instr, NOP_I);
      checkOutput("stall_dec_pc", bus_if.if2dec_pc, 32'h18);
      checkOutput("stall_ic_valid", 32'(bus_if.if2ic_valid), 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    @(posedge clk); #1;
    checkOutput("post_stall_ic_valid", 32'(bus_if.if2ic_valid), 32'd1);
    checkOutput("post_stall_addr", bus_if.if2ic_addr, 32'h1C);

    // park 0x1C, then flush to the branch at 0x10 with ready high
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    waitDecValid(20);
    exp_req.push_back(32'h10);
    exp_req.push_back(32'hC);
    exp_req.push_back(32'h10);
    exp_req.push_back(32'h14);
    pushDec(BR_I, 32'h10, 1'b1);
    pushDec(NOP_I, 32'hC, 1'b0);
    pushDec(BR_I, 32'h10, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h10, 1'b1);
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("flush_out_dec_valid", 32'(bus_if.if2dec_valid), 32'd0);
    checkOutput("flush_out_ic_valid", 32'(bus_if.if2ic_valid), 32'd1);
    checkOutput("flush_out_addr", bus_if.if2ic_addr, 32'h10);
    waitAcc(5, 50);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    waitAcc(7, 50);

    // park 0x14, redirect to 0x20, then flush while 0x20 is outstanding
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    waitDecValid(20);
    exp_req.push_back(32'h20);
    applyStimulus(1'b0, 1'b1, 32'h20, 1'b0);
    @(posedge clk); #1;
    exp_req.push_back(32'h100);
    exp_req.push_back(32'h104);
    pushDec(NOP_I, 32'h100, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h100, 1'b0);
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("drain_ic_valid", 32'(bus_if.if2ic_valid), 32'd0);
    checkOutput("drain_pc", bus_if.if2ic_addr, 32'h100);
    @(posedge clk); #1;
    checkOutput("drain_ic_valid_2", 32'(bus_if.if2ic_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("after_drain_ic_valid", 32'(bus_if.if2ic_valid), 32'd1);
    checkOutput("after_drain_addr", bus_if.if2ic_addr, 32'h100);
    checkOutput("after_drain_dec_valid", 32'(bus_if.if2dec_valid), 32'd0);
    waitAcc(8, 50);

    // freeze mid-REQ with a response and a flush presented
    resp_en     = 1'b0;
    rdy         = 1'b0;
    force_valid = 1'b1;
    force_instr = JAL_I;
    applyStimulus(1'b1, 1'b1, 32'h200, 1'b0);
    pushDec(NOP_I, 32'h104, 1'b0);
    exp_req.push_back(32'h108);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("freeze_ic_valid", 32'(bus_if.if2ic_valid), 32'd1);
      checkOutput("freeze_addr", bus_if.if2ic_addr, 32'h104);
      checkOutput("freeze_dec_valid", 32'(bus_if.if2dec_valid), 32'd0);
    end
    rdy         = 1'b1;
    force_valid = 1'b0;
    resp_en     = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    waitAcc(9, 50);

    // park 0x108 and hit it with an asynchronous reset between edges
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    waitDecValid(20);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_dec_valid", 32'(bus_if.if2dec_valid), 32'd0);
    checkOutput("async_rst_ic_valid", 32'(bus_if.if2ic_valid), 32'd0);
    checkOutput("async_rst_dec_pc", bus_if.if2dec_pc, 32'h0);
    exp_req.push_back(32'h0);
    exp_req.push_back(32'h4);
    pushDec(NOP_I, 32'h0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("rerst_ic_valid", 32'(bus_if.if2ic_valid), 32'd1);
    checkOutput("rerst_addr", bus_if.if2ic_addr, 32'h0);
    waitAcc(10, 50);
    repeat (2) begin
      @(posedge clk); #1;
    end
    checkOutput("dec_queue_empty", 32'(exp_dec.size()), 32'd0);
    checkOutput("req_queue_empty", 32'(exp_req.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
